// File: rtl/ms_latch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ms_latch_ctrl_pkg
//   Shared definitions for the shared capture-latch controller slice.
//   - Controller state encoding (IDLE / LOAD / FULL)
//   - Default requester count and source-tag width
//   - Byte width of the latch bank
//   - Small index helper used for the round-robin pointer
//
//   Optional feature macro used by this slice: MS_LATCH_CTRL_LOCK_EN
//   (adds a per-requester lock input to ms_latch_ctrl).
// ---------------------------------------------------------------------------
package ms_latch_ctrl_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int SRCW_DEFAULT = 2;
  localparam int BYTE_W       = 8;

  // IDLE: latch empty, waiting for a request
  // LOAD: latch gate open for one cycle, ack pulsed to the winner
  // FULL: latch holds a byte the consumer has not accepted yet
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } ctrl_state_t;

  // Increment an index modulo n (n >= 1).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ms_rr_arb.sv
// ---------------------------------------------------------------------------
// ms_rr_arb
//   Purely combinational rotate-priority selector. Starting at rr_ptr and
//   walking upward (wrapping at NREQ), the first asserted request wins.
//   The pointer itself is owned by the caller.
//
// Ports
//   req     in   NREQ   request vector
//   rr_ptr  in   SRCW   index with highest priority this cycle
//   any     out  1      at least one request asserted
//   winner  out  SRCW   index of the winning request (0 when none)
//   grant   out  NREQ   one-hot of the winner (all zero when none)
// ---------------------------------------------------------------------------
module ms_rr_arb
  import ms_latch_ctrl_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int SRCW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] rr_ptr,
  output logic            any,
  output logic [SRCW-1:0] winner,
  output logic [NREQ-1:0] grant
);

  // Scan candidates in priority order; the first hit locks out later ones.
  always_comb begin : select
    int cand;
    cand   = 0;
    any    = 1'b0;
    winner = '0;
    grant  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        winner      = SRCW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ms_latch_ctrl.sv
// ---------------------------------------------------------------------------
// ms_latch_ctrl
//   Shares one 8-bit transparent capture latch bank between NREQ byte
//   producers. Round-robin arbitration picks a producer, the controller
//   drives the latch data and a registered gate enable for one cycle, then
//   holds out_valid until the downstream consumer accepts the byte. The
//   latch bank itself lives in the parent.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   SRCW   source tag width, clog2(NREQ)
//
// Ports
//   clk        in   1        system clock (latch gated by lat_g & clk)
//   reset      in   1        synchronous, active-high
//   req        in   NREQ     per-requester byte request
//   req_data   in   NREQ*8   byte of requester i at [8i+7:8i]
//   out_ready  in   1        consumer accepts when out_valid & out_ready
//   req_lock   in   NREQ     (only with MS_LATCH_CTRL_LOCK_EN) keep priority
//   ack        out  NREQ     one-cycle pulse, request i taken
//   lat_g      out  1        latch gate enable, flop driven
//   lat_d      out  8        latch data input
//   out_valid  out  1        latch holds an unconsumed byte
//   out_src    out  SRCW     requester owning the latched byte
//
// Configuration
//   MS_LATCH_CTRL_LOCK_EN defined: a winner with req_lock set keeps the
//   round-robin pointer, so it wins again on its next request. Undefined:
//   pure round-robin, no req_lock port.
// ---------------------------------------------------------------------------
module ms_latch_ctrl
  import ms_latch_ctrl_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int SRCW = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BYTE_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     lat_g,
  output logic [BYTE_W-1:0]        lat_d,
  output logic                     out_valid,
  output logic [SRCW-1:0]          out_src,
  input  logic                     out_ready
`ifdef MS_LATCH_CTRL_LOCK_EN
  ,
  input  logic [NREQ-1:0]          req_lock
`endif
);

  ctrl_state_t       state;
  logic [SRCW-1:0]   rr_ptr;

  logic              arb_any;
  logic [SRCW-1:0]   arb_winner;
  logic [NREQ-1:0]   arb_grant;
  logic [BYTE_W-1:0] win_data;
  logic              take;
  logic              hold_ptr;
  logic [SRCW-1:0]   next_ptr;

  ms_rr_arb #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (arb_any),
    .winner (arb_winner),
    .grant  (arb_grant)
  );

  // Byte of the current winner; the one-hot grant avoids a variable part
  // select on the packed data bus.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_grant[k]) begin
        win_data = req_data[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // A grant is taken when the latch is free: either empty (IDLE) or being
  // drained this very edge (FULL with out_ready). LOAD never arbitrates, so
  // the gate can never reopen over an unconsumed byte.
  always_comb begin
    take = 1'b0;
    case (state)
      IDLE:    take = arb_any;
      FULL:    take = out_ready & arb_any;
      default: take = 1'b0;
    endcase
  end

`ifdef MS_LATCH_CTRL_LOCK_EN
  // A locked winner keeps top priority for its next request.
  assign hold_ptr = |(req_lock & arb_grant);
`else
  assign hold_ptr = 1'b0;
`endif

  assign next_ptr = hold_ptr ? arb_winner
                             : SRCW'(wrap_inc(int'(arb_winner), NREQ));

  // Controller FSM with all outputs registered. ack and lat_g default low
  // every cycle so they are single-cycle pulses in LOAD only. lat_d and
  // out_src keep their value until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      ack       <= '0;
      lat_g     <= 1'b0;
      lat_d     <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
    end else begin
      ack   <= '0;
      lat_g <= 1'b0;

      if (take) begin
        ack     <= arb_grant;
        lat_g   <= 1'b1;
        lat_d   <= win_data;
        out_src <= arb_winner;
        rr_ptr  <= next_ptr;
      end

      case (state)
        IDLE: begin
          if (arb_any) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          out_valid <= 1'b1;
          state     <= FULL;
        end
        FULL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= arb_any ? LOAD : IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ms_latch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ms_latch_ctrl
//   Self-checking bench for ms_latch_ctrl (NREQ=4): directed vector table,
//   hand-written multi-cycle sequences and a randomized run checked against
//   a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ms_latch_ctrl;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        lat_g;
  logic [7:0]  lat_d;
  logic        out_valid;
  logic [1:0]  out_src;
  logic        out_ready;
  logic [3:0]  req_lock_tb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ms_latch_ctrl #(.NREQ(NREQ), .SRCW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .lat_g     (lat_g),
    .lat_d     (lat_d),
    .out_valid (out_valid),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef MS_LATCH_CTRL_LOCK_EN
    ,
    .req_lock  (req_lock_tb)
`endif
  );

  // Reference model: remembers whether a byte is held, whether a grant is
  // in flight this cycle, and the priority pointer as a plain integer.
  int         m_ptr;
  bit         m_valid;
  int         m_load;
  int         m_src;
  logic [7:0] m_data;

  function automatic void model_step(input logic rst, input logic [3:0] rq,
                                     input logic [31:0] dt, input logic rdy,
                                     input logic [3:0] lk);
    int c;
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_load = -1; m_src = 0; m_data = 8'h00;
      return;
    end
    if (m_load >= 0) begin
      m_valid = 1;
      m_load  = -1;
      return;
    end
    if (m_valid && !rdy) return;
    m_valid = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (m_ptr + k) % NREQ;
      if (rq[c]) begin
        m_load = c;
        m_src  = c;
        m_data = dt[8*c +: 8];
`ifdef MS_LATCH_CTRL_LOCK_EN
        m_ptr  = lk[c] ? c : (c + 1) % NREQ;
`else
        m_ptr  = (c + 1) % NREQ;
`endif
        break;
      end
    end
  endfunction

  task automatic applyStimulus(input logic rst, input logic [3:0] rq,
                               input logic [31:0] dt, input logic rdy,
                               input logic [3:0] lk);
    reset       = rst;
    req         = rq;
    req_data    = dt;
    out_ready   = rdy;
    req_lock_tb = lk;
    @(posedge clk);
    #1;
    model_step(rst, rq, dt, rdy, lk);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_ack,
                             input logic e_g, input logic e_v,
                             input logic [1:0] e_src, input logic [7:0] e_d);
    n_checks++;
    if (ack !== e_ack) begin
      n_fail++;
      $display("[TB] FAIL %s ack got %b want %b", tag, ack, e_ack);
    end
    n_checks++;
    if (lat_g !== e_g) begin
      n_fail++;
      $display("[TB] FAIL %s lat_g got %b want %b", tag, lat_g, e_g);
    end
    n_checks++;
    if (out_valid !== e_v) begin
      n_fail++;
      $display("[TB] FAIL %s out_valid got %b want %b", tag, out_valid, e_v);
    end
    n_checks++;
    if (out_src !== e_src) begin
      n_fail++;
      $display("[TB] FAIL %s out_src got %0d want %0d", tag, out_src, e_src);
    end
    n_checks++;
    if (lat_d !== e_d) begin
      n_fail++;
      $display("[TB] FAIL %s lat_d got %h want %h", tag, lat_d, e_d);
    end
  endtask

  task automatic checkModel(input string tag);
    logic [3:0] e_ack;
    e_ack = (m_load >= 0) ? (4'b0001 << m_load) : 4'b0000;
    checkOutput(tag, e_ack, (m_load >= 0), m_valid, 2'(m_src), m_data);
    n_checks++;
    if (lat_g && out_valid) begin
      n_fail++;
      $display("[TB] FAIL %s overlap lat_g=%b out_valid=%b want not both", tag, lat_g, out_valid);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  e_ack;
    logic        e_g;
    logic        e_v;
    logic [1:0]  e_src;
    logic [7:0]  e_d;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1; req = '0; req_data = '0; out_ready = 1'b0; req_lock_tb = '0;

    // Directed table: reset, single grant latency, accept+new req with no
    // bubble, out_ready ignored in LOAD / IDLE, reset during LOAD.
    vecs.push_back(vec_t'{1'b1, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00});
    vecs.push_back(vec_t'{1'b0, 4'b0100, 32'h00A50000, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 8'hA5});
    vecs.push_back(vec_t'{1'b0, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5});
    vecs.push_back(vec_t'{1'b0, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5});
    vecs.push_back(vec_t'{1'b0, 4'b0010, 32'h00003C00, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1, 8'h3C});
    vecs.push_back(vec_t'{1'b0, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h3C});
    vecs.push_back(vec_t'{1'b0, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h3C});
    vecs.push_back(vec_t'{1'b0, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h3C});
    vecs.push_back(vec_t'{1'b0, 4'b1000, 32'h77000000, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd3, 8'h77});
    vecs.push_back(vec_t'{1'b1, 4'b1000, 32'h77000000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00});
    vecs.push_back(vec_t'{1'b0, 4'b1000, 32'h77000000, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd3, 8'h77});
    vecs.push_back(vec_t'{1'b0, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h77});
    vecs.push_back(vec_t'{1'b1, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00});
    vecs.push_back(vec_t'{1'b0, 4'b0011, 32'h00002211, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 8'h11});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].data, vecs[i].rdy, 4'b0000);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_g,
                  vecs[i].e_v, vecs[i].e_src, vecs[i].e_d);
    end

    // All requesters held with consumer always ready: grants 0,1,2,3,0
    // on every other cycle.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000);
    checkOutput("rr_reset", 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      int g;
      g = ((i - 1) / 2) % 4;
      applyStimulus(1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0000);
      checkOutput($sformatf("rr_cyc%0d", i),
                  (i % 2 == 1) ? (4'b0001 << g) : 4'b0000,
                  (i % 2 == 1), (i % 2 == 0), 2'(g), 8'(17 * (g + 1)));
    end

    // Consumer stalls with requests pending: byte held, no gate, no ack.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 4'b1111, 32'h44332211, 1'b0, 4'b0000);
      checkOutput($sformatf("stall%0d", i), 4'b0000, 1'b0, 1'b1, 2'd0, 8'h11);
    end
    applyStimulus(1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0000);
    checkOutput("stall_release", 4'b0010, 1'b1, 1'b0, 2'd1, 8'h22);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0, 4'b0000);
    checkOutput("stall_full", 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22);

`ifdef MS_LATCH_CTRL_LOCK_EN
    // Locked requester 3 keeps winning; after unlock, 0 gets its turn.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000);
    checkModel("lock_reset");
    for (int i = 1; i <= 14; i++) begin
      applyStimulus(1'b0, 4'b1001, 32'h99000088, 1'b1, (i <= 9) ? 4'b1000 : 4'b0000);
      checkModel($sformatf("lock%0d", i));
      if (i == 9 || i == 13) begin
        n_checks++;
        if (ack !== ((i == 9) ? 4'b1000 : 4'b0001)) begin
          n_fail++;
          $display("[TB] FAIL lock_grant%0d ack got %b want %b", i, ack,
                   (i == 9) ? 4'b1000 : 4'b0001);
        end
      end
    end
`endif

    // Randomized traffic against the reference model.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000);
    checkModel("rand_reset");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    4'($urandom_range(0, 15)),
                    $urandom,
                    ($urandom_range(0, 2) != 0),
                    4'($urandom_range(0, 15)));
      checkModel($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
